// File: rtl/mod_exp_engine_if.sv
// Request/result handshake and modulo-LUT port of the modular exponentiation engine.
// The engine connects through the slave modport; the requester and LUT connect through the master modport.
interface mod_exp_engine_if #(
   parameter int EXP_W = 6
) ();
   logic             start;
   logic [5:0]       base;
   logic [EXP_W-1:0] exp;
   logic [5:0]       modulus;
   logic             busy;
   logic             done;
   logic [5:0]       result;
   logic [11:0]      lut_func_in;
   logic [5:0]       lut_div;
   logic [5:0]       lut_func_out;

   modport slave (
      input  start, base, exp, modulus, lut_func_out,
      output busy, done, result, lut_func_in, lut_div
   );

   modport master (
      output start, base, exp, modulus, lut_func_out,
      input  busy, done, result, lut_func_in, lut_div
   );
endinterface

// File: rtl/mod_exp_engine.sv
// Square-and-multiply base^exp mod n for 6-bit operands, MSB-first over all EXP_W exponent bits.
// Every reduction goes through the external registered modulo LUT as an ISSUE/CAPTURE cycle pair.
//
// state    | meaning
// S_IDLE   | waiting for start; LUT inputs held at 0
// S_RED_BASE | reduce base mod n into r_b_red
// S_RED_ONE  | reduce 1 mod n to seed the accumulator (n=1 gives 0)
// S_SQR    | accumulator squared mod n
// S_MUL    | accumulator times reduced base mod n (exp bit set)
module mod_exp_engine #(
   parameter int EXP_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   mod_exp_engine_if.slave    bus
);
   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RED_BASE, S_RED_ONE, S_SQR, S_MUL} state_t;

   state_t           r_state;
   logic             r_cap;
   logic [IDX_W-1:0] r_idx;
   logic [EXP_W-1:0] r_exp;
   logic [5:0]       r_b_red;
   logic [5:0]       r_div;
   logic [5:0]       r_result;
   logic [11:0]      r_func_in;
   logic             r_busy;
   logic             r_done;

   logic [5:0]       w_rem;
   logic [11:0]      w_sq;
   logic [11:0]      w_mulb;
   logic             w_last;

   // The captured remainder is the new accumulator, so the next product is formed from it directly.
   assign w_rem  = bus.lut_func_out;
   assign w_sq   = {6'b0, w_rem} * {6'b0, w_rem};
   assign w_mulb = {6'b0, w_rem} * {6'b0, r_b_red};
   assign w_last = (r_idx == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cap     <= 1'b0;
         r_idx     <= IDX_W'(EXP_W - 1);
         r_exp     <= '0;
         r_b_red   <= '0;
         r_div     <= '0;
         r_result  <= '0;
         r_func_in <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (bus.start) begin
               r_exp     <= bus.exp;
               r_div     <= bus.modulus;
               r_func_in <= {6'b0, bus.base};
               r_idx     <= IDX_W'(EXP_W - 1);
               r_busy    <= 1'b1;
               r_cap     <= 1'b0;
               r_state   <= S_RED_BASE;
            end
         end else if (!r_cap) begin
            r_cap <= 1'b1;
         end else begin
            r_cap <= 1'b0;
            case (r_state)
               S_RED_BASE: begin
                  r_b_red   <= w_rem;
                  r_func_in <= 12'd1;
                  r_state   <= S_RED_ONE;
               end
               S_RED_ONE: begin
                  r_func_in <= w_sq;
                  r_state   <= S_SQR;
               end
               default: begin
                  if (r_state == S_SQR && r_exp[r_idx]) begin
                     r_func_in <= w_mulb;
                     r_state   <= S_MUL;
                  end else if (w_last) begin
                     r_result  <= w_rem;
                     r_done    <= 1'b1;
                     r_busy    <= 1'b0;
                     r_func_in <= '0;
                     r_div     <= '0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_idx     <= r_idx - 1'b1;
                     r_func_in <= w_sq;
                     r_state   <= S_SQR;
                  end
               end
            endcase
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.result      = r_result;
   assign bus.lut_func_in = r_func_in;
   assign bus.lut_div     = r_div;
endmodule
